// File: rtl/snn_io_pkg.sv
// Shared constants for the SNN pad bridge: register word offsets, ID fields,
// reset values and the bus handshake state type.
package snn_io_pkg;

    // Register word index, taken from byte address bits [4:2]
    localparam logic [2:0] OFS_OUT      = 3'd0;
    localparam logic [2:0] OFS_OEB      = 3'd1;
    localparam logic [2:0] OFS_IN       = 3'd2;
    localparam logic [2:0] OFS_IRQ_MASK = 3'd3;
    localparam logic [2:0] OFS_IRQ_STAT = 3'd4;
    localparam logic [2:0] OFS_RISE_EN  = 3'd5;
    localparam logic [2:0] OFS_FALL_EN  = 3'd6;
    localparam logic [2:0] OFS_ID       = 3'd7;

    // ID register fields
    localparam logic [7:0] ID_MAGIC   = 8'h5B;
    localparam logic [7:0] ID_VERSION = 8'h01;

    // All pads come up as inputs (output-enable is active-low)
    localparam logic [31:0] OEB_RESET = 32'hFFFF_FFFF;

    // Bus handshake: idle, or presenting the single-cycle acknowledge
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/snn_io_edge_sync.sv
// Per-pad two-flop synchroniser with a history flop and edge detection.
// Flops reset to 0, so a pad already high at reset release looks like a rise.
module snn_io_edge_sync #(
    parameter int unsigned N_IO = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_IO-1:0] pad_i,
    input  logic [N_IO-1:0] rise_en_i,
    input  logic [N_IO-1:0] fall_en_i,
    output logic [N_IO-1:0] sync_o,
    output logic [N_IO-1:0] edge_o
);

    logic [N_IO-1:0] s1_q, s2_q, s3_q;

    // Shift asynchronous pad values through s1 -> s2, keep previous s2 in s3
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= pad_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign edge_o = (s2_q & ~s3_q & rise_en_i) | (~s2_q & s3_q & fall_en_i);

endmodule

// File: rtl/snn_io_bridge.sv
// Wishbone-slave GPIO/IRQ bridge: pad output/enable registers, synchronised
// input readback and edge interrupts folded onto N_IRQ level outputs.
module snn_io_bridge
    import snn_io_pkg::*;
#(
    parameter int unsigned N_IO      = 16,
    parameter int unsigned N_IRQ     = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [N_IO-1:0]  io_in,
    output logic [N_IO-1:0]  io_out,
    output logic [N_IO-1:0]  io_oeb,
    output logic [N_IRQ-1:0] irq
);

    bus_state_e state_q, state_d;
    logic       req, in_win, wr_hit, rd_hit;
    logic [2:0] word_sel;

    logic [N_IO-1:0] lane_mask, wdata;
    logic [N_IO-1:0] out_q, out_d, oeb_q, oeb_d, mask_q, mask_d;
    logic [N_IO-1:0] stat_q, stat_d, rise_q, rise_d, fall_q, fall_d;
    logic [N_IO-1:0] pad_sync, pad_event;
    logic [31:0]     dat_q, dat_d, rd_word;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0][N_IO-1:0] fold_terms;
    logic            unused_bus_bits;

    // Bus lanes above N_IO carry nothing for this block
    assign unused_bus_bits = ^{wbs_dat_i, wbs_sel_i};

    // A new request is only accepted while ack is low
    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign in_win   = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    assign wr_hit   = req & wbs_we_i & in_win;
    assign rd_hit   = req & ~wbs_we_i & in_win;
    assign word_sel = wbs_adr_i[4:2];
    assign wdata    = wbs_dat_i[N_IO-1:0];

    for (genvar gi = 0; gi < N_IO; gi++) begin : g_lane
        assign lane_mask[gi] = wbs_sel_i[gi/8];
    end

    snn_io_edge_sync #(.N_IO(N_IO)) u_edge_sync (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .pad_i     (io_in),
        .rise_en_i (rise_q),
        .fall_en_i (fall_q),
        .sync_o    (pad_sync),
        .edge_o    (pad_event)
    );

    // Handshake state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= BUS_IDLE;
        else            state_q <= state_d;
    end

    // Handshake next state: ack for exactly one cycle after a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (req) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Handshake outputs: read data travels with ack and is zero otherwise
    always_comb begin
        wbs_ack_o = (state_q == BUS_ACK);
        wbs_dat_o = dat_q;
    end

    // Register writes with byte-lane gating; new edges win over a W1C clear
    always_comb begin
        out_d  = out_q;
        oeb_d  = oeb_q;
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr_hit) begin
            case (word_sel)
                OFS_OUT:      out_d  = (out_q  & ~lane_mask) | (wdata & lane_mask);
                OFS_OEB:      oeb_d  = (oeb_q  & ~lane_mask) | (wdata & lane_mask);
                OFS_IRQ_MASK: mask_d = (mask_q & ~lane_mask) | (wdata & lane_mask);
                OFS_RISE_EN:  rise_d = (rise_q & ~lane_mask) | (wdata & lane_mask);
                OFS_FALL_EN:  fall_d = (fall_q & ~lane_mask) | (wdata & lane_mask);
                OFS_IRQ_STAT: stat_d = stat_q & ~(wdata & lane_mask);
                default:      ;
            endcase
        end
        stat_d = stat_d | pad_event;
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_word = '0;
        case (word_sel)
            OFS_OUT:      rd_word = 32'(out_q);
            OFS_OEB:      rd_word = 32'(oeb_q);
            OFS_IN:       rd_word = 32'(pad_sync);
            OFS_IRQ_MASK: rd_word = 32'(mask_q);
            OFS_IRQ_STAT: rd_word = 32'(stat_q);
            OFS_RISE_EN:  rd_word = 32'(rise_q);
            OFS_FALL_EN:  rd_word = 32'(fall_q);
            OFS_ID:       rd_word = {ID_MAGIC, 8'(N_IRQ), 8'(N_IO), ID_VERSION};
        endcase
        dat_d = rd_hit ? rd_word : '0;
    end

    // Pad p contributes to irq line p mod N_IRQ
    for (genvar gk = 0; gk < N_IRQ; gk++) begin : g_irq
        for (genvar gi = 0; gi < N_IO; gi++) begin : g_pad
            if ((gi % N_IRQ) == gk) begin : g_hit
                assign fold_terms[gk][gi] = stat_q[gi] & mask_q[gi];
            end else begin : g_miss
                assign fold_terms[gk][gi] = 1'b0;
            end
        end
        assign irq_d[gk] = |fold_terms[gk];
    end

    // Register file, read data and folded irq state
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q  <= '0;
            oeb_q  <= OEB_RESET[N_IO-1:0];
            mask_q <= '0;
            stat_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            dat_q  <= '0;
            irq_q  <= '0;
        end else begin
            out_q  <= out_d;
            oeb_q  <= oeb_d;
            mask_q <= mask_d;
            stat_q <= stat_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    assign io_out = out_q;
    assign io_oeb = oeb_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_snn_io_bridge.sv
// Self-checking bench for snn_io_bridge (N_IO=16, N_IRQ=3).
module tb_snn_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [15:0] io_in, io_out, io_oeb;
    logic [2:0]  irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_out, m_oeb, m_mask, m_stat, m_rise, m_fall, pads;
    localparam logic [31:0] ID_EXP = 32'h5B03_1001;

    snn_io_bridge dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input int idx);
        return 32'h3000_0100 + 32'(idx * 4);
    endfunction

    function automatic logic [15:0] lanes(input logic [3:0] s);
        logic [15:0] m;
        m = 16'h0000;
        if (s[0]) m = m | 16'h00FF;
        if (s[1]) m = m | 16'hFF00;
        return m;
    endfunction

    function automatic logic [2:0] model_irq(input logic [15:0] st, input logic [15:0] mk);
        logic [2:0] r;
        r = 3'b000;
        for (int p = 0; p < 16; p++)
            if (st[p] && mk[p]) r[p % 3] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        case (idx)
            0: return {16'h0, m_out};
            1: return {16'h0, m_oeb};
            2: return {16'h0, pads};
            3: return {16'h0, m_mask};
            4: return {16'h0, m_stat};
            5: return {16'h0, m_rise};
            6: return {16'h0, m_fall};
            default: return ID_EXP;
        endcase
    endfunction

    task automatic model_wr(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [15:0] lm, dv;
        lm = lanes(s);
        dv = d[15:0];
        case (idx)
            0: m_out  = (m_out  & ~lm) | (dv & lm);
            1: m_oeb  = (m_oeb  & ~lm) | (dv & lm);
            3: m_mask = (m_mask & ~lm) | (dv & lm);
            4: m_stat = m_stat & ~(dv & lm);
            5: m_rise = (m_rise & ~lm) | (dv & lm);
            6: m_fall = (m_fall & ~lm) | (dv & lm);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_out = 16'h0; m_oeb = 16'hFFFF; m_mask = 16'h0;
        m_stat = 16'h0; m_rise = 16'h0; m_fall = 16'h0;
    endtask

    // One Wishbone transfer; ack expected exactly one cycle after the request
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int waited;
        waited = 0;
        @(negedge clk);
        check("dat_idle", dat_r, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 4);
        check("ack_latency", 32'(waited), 32'd1);
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("xfer we=%0b adr=%h wdat=%h sel=%b rdat=%h", w, a, d, s, rd);
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        bus_xfer(1'b1, reg_addr(idx), d, s, rd);
        model_wr(idx, d, s);
    endtask

    task automatic rd_check(input string tag, input int idx);
        logic [31:0] rd;
        bus_xfer(1'b0, reg_addr(idx), 32'h0, 4'hF, rd);
        check(tag, rd, model_rd(idx));
    endtask

    initial begin
        logic [31:0] rd, d, a;
        logic [31:0] oow [3];
        logic [15:0] nv, ev;
        logic [3:0]  s;
        int idx, wsel, acks;

        oow[0] = 32'h3000_0200; oow[1] = 32'h3000_0120; oow[2] = 32'h2000_0100;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        rst_n = 1'b0;
        pads = 16'($urandom);
        pads[4] = 1'b0;
        io_in = pads;
        model_reset();

        // Reset state
        #13;
        check("rst_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("rst_out", {16'h0, io_out}, 32'h0);
        check("rst_irq", {29'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", dat_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ID and basic write/readback with byte-lane gating
        rd_check("id", 7);
        wr_reg(0, 32'h0000_A5A5, 4'b0001);
        check("out_lane0", {16'h0, io_out}, 32'h0000_00A5);
        rd_check("out_rd", 0);

        // Randomised register traffic, including out-of-window accesses
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, 8);
            wsel = $urandom_range(0, 1);
            d    = $urandom;
            s    = 4'($urandom);
            a    = (idx == 8) ? oow[$urandom_range(0, 2)] : reg_addr(idx);
            bus_xfer(wsel[0], a, d, s, rd);
            if (wsel[0]) begin
                if (idx != 8) model_wr(idx, d, s);
                check("rnd_io_out", {16'h0, io_out}, {16'h0, m_out});
                check("rnd_io_oeb", {16'h0, io_oeb}, {16'h0, m_oeb});
            end else begin
                check("rnd_rd", rd, (idx == 8) ? 32'h0 : model_rd(idx));
            end
        end
        check("rnd_irq", {29'h0, irq}, 32'h0);

        // Quiet state before the edge tests
        wr_reg(5, 32'h0, 4'hF);
        wr_reg(6, 32'h0, 4'hF);
        wr_reg(3, 32'h0, 4'hF);
        wr_reg(4, 32'hFFFF, 4'hF);
        rd_check("stat_clr", 4);

        // Rise on pad 4: status two edges after sampling, irq line 1 one edge later
        wr_reg(5, 32'h0010, 4'hF);
        wr_reg(3, 32'h0010, 4'hF);
        @(negedge clk);
        pads[4] = 1'b1;
        io_in = pads;
        @(negedge clk);
        check("edge_irq_e0", {29'h0, irq}, 32'h0);
        bus_xfer(1'b0, reg_addr(4), 32'h0, 4'hF, rd);
        check("edge_stat_e2", rd, 32'h0);
        check("edge_irq_e2", {29'h0, irq}, 32'h0);
        @(negedge clk);
        check("edge_irq_e3", {29'h0, irq}, 32'h2);
        m_stat = 16'h0010;
        rd_check("edge_stat", 4);

        // Masking drops irq next cycle without touching status
        wr_reg(3, 32'h0, 4'hF);
        check("mask_irq_w", {29'h0, irq}, 32'h2);
        @(negedge clk);
        check("mask_irq_next", {29'h0, irq}, 32'h0);
        rd_check("mask_stat", 4);
        wr_reg(3, 32'h0010, 4'hF);

        // W1C on an unselected lane does nothing
        pads[4] = 1'b0;
        io_in = pads;
        repeat (4) @(negedge clk);
        wr_reg(4, 32'h0010, 4'b0010);
        rd_check("w1c_lane", 4);

        // Rise lands on the same edge as the clear: set wins
        @(negedge clk);
        pads[4] = 1'b1;
        io_in = pads;
        @(negedge clk);
        bus_xfer(1'b1, reg_addr(4), 32'h0010, 4'b0001, rd);
        rd_check("w1c_race", 4);
        check("w1c_race_irq", {29'h0, irq}, 32'h2);

        // Clear without an edge
        wr_reg(4, 32'h0010, 4'b0001);
        @(negedge clk);
        check("w1c_irq", {29'h0, irq}, 32'h0);
        rd_check("w1c_stat", 4);

        // Random pad patterns against edge enables and mask
        wr_reg(5, $urandom, 4'hF);
        wr_reg(6, $urandom, 4'hF);
        wr_reg(3, $urandom, 4'hF);
        wr_reg(4, 32'hFFFF, 4'hF);
        for (int i = 0; i < 12; i++) begin
            nv = 16'($urandom);
            ev = (nv & ~pads & m_rise) | (~nv & pads & m_fall);
            m_stat = m_stat | ev;
            pads = nv;
            io_in = pads;
            repeat (5) @(negedge clk);
            check("pat_irq", {29'h0, irq}, {29'h0, model_irq(m_stat, m_mask)});
            rd_check("pat_in", 2);
            rd_check("pat_stat", 4);
            wr_reg(4, $urandom, 4'hF);
        end

        // Out-of-window writes change nothing
        bus_xfer(1'b1, 32'h3000_0200, 32'hFFFF_FFFF, 4'hF, rd);
        bus_xfer(1'b1, 32'h3001_0104, 32'hFFFF_FFFF, 4'hF, rd);
        for (int r = 0; r < 8; r++) rd_check("oow_keep", r);

        // Back-to-back: six cycles of held request give three acks
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = reg_addr(0); dat_w = 32'h0000_3C3C; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b_ack", {31'h0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
            acks += int'(ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("b2b acks=%0d", acks);
        check("b2b_count", 32'(acks), 32'd3);
        m_out = 16'h3C3C;
        check("b2b_out", {16'h0, io_out}, 32'h0000_3C3C);

        // Reset while ack is high clears bus outputs at once
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = reg_addr(7);
        @(posedge clk);
        #2;
        check("mid_ack", {31'h0, ack}, 32'h1);
        check("mid_dat", dat_r, ID_EXP);
        rst_n = 1'b0;
        #1;
        check("async_ack", {31'h0, ack}, 32'h0);
        check("async_dat", dat_r, 32'h0);
        check("async_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        check("async_out", {16'h0, io_out}, 32'h0);
        check("async_irq", {29'h0, irq}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rd_check("post_rst_out", 0);
        rd_check("post_rst_oeb", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_io_bridge.md
Name: snn_io_bridge

Overview:
- Parametrised Wishbone-slave GPIO/IRQ bridge between the management SoC bus and the user pads used by the SNN core.
- Generalises the fixed 16-pad mapping into N_IO configurable pads.
- Each pad has software-driven output data and output-enable, a synchronised input readback, and per-pad edge-detect interrupts folded onto N_IRQ user IRQ lines.
- Instantiated beside the snn core inside the user project wrapper.

Parameters:
- N_IO, 16, number of pads handled (1..32)
- N_IRQ, 3, number of IRQ outputs
- BASE_ADDR, 32'h3000_0100, Wishbone base address of the register window
- ADDR_MASK, 32'hFFFF_FFE0, bits compared against BASE_ADDR for decode (32-byte window)

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  N_IO  pad inputs (asynchronous)
- io_out  out  N_IO  pad output data
- io_oeb  out  N_IO  pad output-enable, active-low
- irq  out  N_IRQ  level interrupts

Behaviour:
- Reset (async assert, sync release): ack=0, dat_o=0, io_out=0, io_oeb=all 1s (all pads inputs), irq=0, all registers 0 except OEB.
- Register map (word offset, bits [N_IO-1:0]; unused upper bits read 0, ignore writes):
  - 0x00 OUT, RW
  - 0x04 OEB, RW, reset all 1s
  - 0x08 IN, RO, synchronised pad value
  - 0x0C IRQ_MASK, RW
  - 0x10 IRQ_STAT, W1C
  - 0x14 RISE_EN, RW
  - 0x18 FALL_EN, RW
  - 0x1C ID, RO, {8'h5B, 8'(N_IRQ), 8'(N_IO), 8'h01}
- Bus handshake:
  - Request = cyc & stb & ~ack.
  - ack is registered: high exactly one cycle, the cycle after the request is seen; low the following cycle. Max one transfer per 2 cycles.
  - Write takes effect on the same edge that raises ack.
  - Read data is registered alongside ack; dat_o = 0 whenever ack = 0.
- Byte lanes: wbs_sel_i[k] gates bits [8k+7:8k] on writes. For W1C, only selected lanes clear.
- Out-of-window address (adr & ADDR_MASK != BASE_ADDR): still acked; reads return 0, writes ignored. The bus never hangs.
- Input path:
  - Two-flop synchroniser s1 -> s2, plus history flop s3.
  - rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
  - IN register = s2.
  - Latency: pad change sampled at edge 0, IRQ_STAT bit set at edge 2, irq set at edge 3.
- IRQ_STAT: bit set on rise|fall. If set and W1C clear hit the same bit in the same cycle, set wins.
- irq[k] registered = OR over pads p with p mod N_IRQ == k of (IRQ_STAT[p] & IRQ_MASK[p]). Masking an already-set bit drops irq the next cycle; status is unchanged.
- Reset mid-transaction: ack and dat_o go 0 immediately; the pending write is lost; the master must retry.
- Neither flop stage of the synchroniser is reset to a pad-dependent value; s1/s2/s3 reset to 0. An input high at reset release therefore produces a rise event if RISE_EN is set. Software enables edges after reset, so this is acceptable.

Decomposition:
- Shared package snn_io_pkg holds:
  - register offset constants (OFS_OUT..OFS_ID)
  - ID magic 8'h5B and version 8'h01
  - reset value of OEB
- One natural sub-module: snn_io_edge_sync, per-pad synchroniser plus edge detector, parametrised by width N_IO. The top holds the bus FSM, registers and IRQ folding.

Test Plan:
- Reset: assert wb_rst_ni=0 mid-cycle -> io_oeb=16'hFFFF, io_out=0, irq=0 asynchronously; read ID -> 32'h5B03_1001.
- Write/readback: write OUT=32'h0000_A5A5 sel=4'b0001 -> io_out=16'h00A5; read OUT -> 32'h0000_00A5; ack high exactly one cycle after each request.
- Edge IRQ: RISE_EN=16'h0010, IRQ_MASK=16'h0010; drive io_in[4] 0->1 -> IRQ_STAT=0x10 two edges later; irq=3'b010 one edge after that (4 mod 3 = 1).
- W1C race: hold io_in[4] toggling so a rise lands the same cycle as a write IRQ_STAT=0x10 -> bit stays 1; clear with no edge -> bit 0, irq=0 next cycle.
- Out-of-window: read 0x3000_0200 -> ack after 1 cycle, data 0; write there -> no register changes.
- Back-to-back: hold cyc/stb high for 6 cycles with we=1 -> exactly 3 acks, alternating cycles.
